// File: rtl/full_adder_dataflow_reg.sv
// Registered ripple-carry adder built from dataflow full-adder cells.
// Computes a + b + c in WIDTH+1 bits and captures {carry, sum} with a
// valid flag one cycle after in_valid. WIDTH = 1 is a single full adder.
module full_adder_dataflow_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] s;
  logic             k_out;
  logic             k_run;

  // Ripple chain: each cell is sum = a ^ b ^ k, carry = majority(a, b, k),
  // with the carry-in seeding bit 0. A running variable keeps the chain
  // free of self-referencing vector bits.
  always_comb begin
    s     = '0;
    k_run = c;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ k_run;
      k_run = (a[i] & b[i]) | (a[i] & k_run) | (b[i] & k_run);
    end
    k_out = k_run;
  end

  // Output registers: capture on in_valid, otherwise hold sum/carry and
  // drop the valid flag. Operands are ignored entirely when not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= k_out;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_dataflow_reg.sv
// Self-checking bench for full_adder_dataflow_reg at WIDTH = 1, 8 and 16.
module tb_full_adder_dataflow_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic        s1, k1, o1;
  logic        v8 = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        k8, o8;
  logic        v16 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        k16, o16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder_dataflow_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .sum(s1), .carry(k1), .out_valid(o1));

  full_adder_dataflow_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8), .carry(k8), .out_valid(o8));

  full_adder_dataflow_reg #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c(c16),
    .sum(s16), .carry(k16), .out_valid(o16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] m_sum;
    logic        m_carry, m_valid;
    logic [1:0]  tt;
    logic        ra, rb, rc;

    // Reset values before any clock edge.
    #2;
    check("rst_w1", {o1, k1, s1}, 3'b000);
    check("rst_w8", {o8, k8, s8}, 10'h0);
    check("rst_w16", {o16, k16, s16}, 18'h0);
    @(negedge clk);
    rst = 1'b0;

    // Capture 1+1+1 on the 1-bit adder, then reset asynchronously mid-cycle.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    step();
    check("pre_rst_w1", {o1, k1, s1}, 3'b111);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_w1", {o1, k1, s1}, 3'b000);
    step();
    check("rst_hold_w1", {o1, k1, s1}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 truth table, one combination per cycle.
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0]; v1 = 1'b1;
      tt = 2'(a1) + 2'(b1) + 2'(c1);
      step();
      check($sformatf("tt_w1_%0d", i), {o1, k1, s1}, {1'b1, tt});
    end
    v1 = 1'b0;
    step();
    check("tt_w1_drop", o1, 1'b0);

    // WIDTH=8 carry propagation through the whole chain.
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    step();
    check("prop_ff_00_1", {o8, k8, s8}, {1'b1, 1'b1, 8'h00});
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    step();
    check("prop_ff_ff_1", {o8, k8, s8}, {1'b1, 1'b1, 8'hFF});
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    step();
    check("zero_00_00_0", {o8, k8, s8}, {1'b1, 1'b0, 8'h00});

    // Hold: capture 0x12 + 0x34, then drop in_valid with random operands.
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    step();
    check("hold_capture", {o8, k8, s8}, {1'b1, 1'b0, 8'h46});
    v8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      step();
      check($sformatf("hold_%0d", i), {o8, k8, s8}, {1'b0, 1'b0, 8'h46});
    end

    // Back-to-back valid cycles.
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    step();
    check("b2b_0", {o8, k8, s8}, {1'b1, 1'b0, 8'h02});
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    step();
    check("b2b_1", {o8, k8, s8}, {1'b1, 1'b1, 8'h00});
    a8 = 8'h7F; b8 = 8'h00; c8 = 1'b1;
    step();
    check("b2b_2", {o8, k8, s8}, {1'b1, 1'b0, 8'h80});
    v8 = 1'b0;
    step();
    check("b2b_end", {o8, k8, s8}, {1'b0, 1'b0, 8'h80});

    // Randomized WIDTH=16 against an arithmetic model with one-cycle delay.
    m_sum = '0; m_carry = 1'b0; m_valid = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      v16 = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if (n % 97 == 0) begin
        a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
      end
      if (v16) begin
        full = 17'(a16) + 17'(b16) + 17'(c16);
        m_sum = full[15:0];
        m_carry = full[16];
      end
      m_valid = v16;
      step();
      check("rnd_valid", o16, m_valid);
      check("rnd_sum", s16, m_sum);
      check("rnd_carry", k16, m_carry);
    end
    v16 = 1'b0;

    // Operand inputs of the other instances must not matter while idle.
    ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
    a1 = ra; b1 = rb; c1 = rc;
    step();
    check("idle_w1", {o1, k1, s1}, 3'b011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
